multi_push_pop_fifo: RTL and testbench
======================================

# multi_push_pop_fifo

Synchronous FIFO that accepts up to N words and delivers up to N words per clock. Push and pop are expressed as counts, not single-bit strobes. It sits between variable-rate producers and consumers in the UART/FFT data path, for example a byte packer feeding a framer. Read data is presented combinationally from the head of the queue, so a consumer can inspect up to N words before committing a pop.

## Interface
- W, 8, data word width in bits
- D, 4, storage depth in words (≥1; need not be a power of two)
- N, 4, maximum words pushed or popped per cycle (≥1)
- WN (localparam), $clog2(N+1), width of count ports
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- push  in  WN  number of words to enqueue this cycle (0..N)
- push_data  in  N×W packed  push_data[i] is enqueued i-th; only indices < push are used
- pop  in  WN  number of words to dequeue this cycle (0..N)
- pop_data  out  N×W packed  pop_data[i] = i-th oldest stored word
- can_push  out  WN  max words accepted this cycle = min(N, D − count)
- can_pop  out  WN  max words available this cycle = min(N, count)

## Operation
- State: circular memory of D words, read pointer rd, write pointer wr (0..D−1), and occupancy count (0..D, width $clog2(D+1)).
- Effective push: ep = min(push, can_push).
- Effective pop: eo = min(pop, can_pop).
- Requests above the limits are silently clipped. They are not errors and do not corrupt state.
- Push: for i < ep, mem[(wr+i) mod D] ← push_data[i]; wr ← (wr+ep) mod D.
- Pop: rd ← (rd+eo) mod D.
- count ← count + ep − eo.
- Modulo wrap is done by conditional subtraction of D, so non-power-of-2 depths are supported.
- pop_data[i] = mem[(rd+i) mod D] for all i < N, computed combinationally.
- Entries at indices ≥ can_pop are don't-care (stale memory). Verification must not check them.
- can_push and can_pop depend only on the registered count. A same-cycle pop does not free space for a same-cycle push, and a same-cycle push cannot be popped in the same cycle.
- Simultaneous push and pop are both applied in one cycle.
- Order is strictly FIFO across wrap-around.

## Timing
- Reset (rst=0, asynchronous): rd=0, wr=0, count=0.
- Reset output values: can_push=min(N,D), can_pop=0. pop_data content is undefined; the memory is not cleared.
- Reset mid-operation discards all stored data immediately. After rst is released the FIFO is empty.
- All state updates occur on the rising clk edge after rst is released (rst=1).
- Write-to-read latency is 1 cycle: words pushed at edge k appear on pop_data, and in can_pop, right after edge k.
- pop_data, can_push and can_pop change only after a clock edge or on reset. They are never combinational from push or pop.
- Full (count=D): can_push=0, and any push is ignored.
- Empty (count=0): can_pop=0, and any pop is ignored.

## Test plan
- Reset → can_push=4, can_pop=0. Hold for 3 cycles; outputs stay constant.
- After reset, push=3 with data {1,2,3,4} → next cycle can_pop=3, can_push=1, pop_data[0..2]=1,2,3. Word 4 is not stored.
- Three consecutive cycles with pop=1 → pop_data[0] reads 1, then 2, then 3. can_pop goes 2, 1, 0, and can_push returns to 4.
- Wrap test, continuing with rd=wr=3: push=3 with {6,7,8,9} → pop_data[0..2]=6,7,8 across the wrap. Then pop=2 → can_pop=1, pop_data[0]=8.
- Full and clip: push=3 then push=3 → second push accepted only 1 word, count=4, can_push=0. A further push=2 is ignored. Then pop=4 returns all 4 words in order.
- Simultaneous ops: with count=2, push=2 and pop=2 in one cycle → count stays 2, and pop_data holds exactly the two new words in order.
- Async reset asserted mid-cycle while count=3 → can_pop=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_push_pop_fifo.sv
// multi_push_pop_fifo
// Circular-buffer FIFO that enqueues and dequeues up to N words per clock.
// Push/pop are word counts; requests beyond what the FIFO can accept or
// supply are silently clipped. The head N words are visible combinationally
// on pop_data so a consumer can look ahead before committing a pop.
module multi_push_pop_fifo #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int N = 4,
  localparam int WN = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WN-1:0]       push,
  input  logic [N-1:0][W-1:0] push_data,
  input  logic [WN-1:0]       pop,
  output logic [N-1:0][W-1:0] pop_data,
  output logic [WN-1:0]       can_push,
  output logic [WN-1:0]       can_pop
);

  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned DU = D;
  localparam int unsigned NU = N;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [CW-1:0] count;
  logic [WN-1:0] ep;
  logic [WN-1:0] eo;

  // Pointer advance modulo D by repeated conditional subtraction, so any
  // depth works; the loop bound covers offsets up to N-1 past a pointer.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    for (int k = 0; k < N / D + 1; k++) begin
      if (s >= DU) s = s - DU;
    end
    return PW'(s);
  endfunction

  // Acceptance and availability limits derived only from registered count.
  always_comb begin
    int unsigned space;
    int unsigned avail;
    space    = DU - 32'(count);
    avail    = 32'(count);
    can_push = WN'((space > NU) ? NU : space);
    can_pop  = WN'((avail > NU) ? NU : avail);
    ep       = (push > can_push) ? can_push : push;
    eo       = (pop > can_pop) ? can_pop : pop;
  end

  // Head-of-queue view: the i-th oldest word on lane i.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < N; i++) begin
      pop_data[i] = mem[wrap_add(rd, i)];
    end
  end

  // Storage write; memory is intentionally not cleared on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (i < int'(ep)) mem[wrap_add(wr, i)] <= push_data[i];
    end
  end

  // Pointer and occupancy update; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      wr    <= wrap_add(wr, 32'(ep));
      rd    <= wrap_add(rd, 32'(eo));
      count <= count + CW'(ep) - CW'(eo);
    end
  end

endmodule

// File: tb/tb_multi_push_pop_fifo.sv
// tb_multi_push_pop_fifo
// Directed bench for multi_push_pop_fifo with default parameters
// (W=8, D=4, N=4). Each task drives one scenario and checks inline.
module tb_multi_push_pop_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int N  = 4;
  localparam int WN = $clog2(N + 1);

  logic                clk;
  logic                rst;
  logic [WN-1:0]       push;
  logic [N-1:0][W-1:0] push_data;
  logic [WN-1:0]       pop;
  logic [N-1:0][W-1:0] pop_data;
  logic [WN-1:0]       can_push;
  logic [WN-1:0]       can_pop;

  int test_count;
  int fail_count;

  multi_push_pop_fifo #(.W(W), .D(D), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .can_push  (can_push),
    .can_pop   (can_pop)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    push = '0;
    pop = '0;
    push_data = '0;
    repeat (2) step();
    test_count++;
    if (can_pop !== 3'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_can_pop: got %0d expected 0", can_pop);
    end
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      test_count++;
      if (can_push !== 3'd4) begin
        fail_count++;
        $display("[TB] FAIL reset_hold_can_push[%0d]: got %0d expected 4", c, can_push);
      end
      test_count++;
      if (can_pop !== 3'd0) begin
        fail_count++;
        $display("[TB] FAIL reset_hold_can_pop[%0d]: got %0d expected 0", c, can_pop);
      end
    end
  endtask

  task automatic test_push_clip();
    logic [7:0] exp [3];
    exp = '{8'd1, 8'd2, 8'd3};
    push = 3'd3;
    push_data = {8'd4, 8'd3, 8'd2, 8'd1};
    step();
    push = '0;
    test_count++;
    if (can_pop !== 3'd3) begin
      fail_count++;
      $display("[TB] FAIL push3_can_pop: got %0d expected 3", can_pop);
    end
    test_count++;
    if (can_push !== 3'd1) begin
      fail_count++;
      $display("[TB] FAIL push3_can_push: got %0d expected 1", can_push);
    end
    for (int i = 0; i < 3; i++) begin
      test_count++;
      if (pop_data[i] !== exp[i]) begin
        fail_count++;
        $display("[TB] FAIL push3_data[%0d]: got %0d expected %0d", i, pop_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_pop_single();
    logic [7:0] exp_head [3];
    logic [2:0] exp_cnt [3];
    exp_head = '{8'd1, 8'd2, 8'd3};
    exp_cnt  = '{3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 3; c++) begin
      test_count++;
      if (pop_data[0] !== exp_head[c]) begin
        fail_count++;
        $display("[TB] FAIL pop1_head[%0d]: got %0d expected %0d", c, pop_data[0], exp_head[c]);
      end
      pop = 3'd1;
      step();
      pop = '0;
      test_count++;
      if (can_pop !== exp_cnt[c]) begin
        fail_count++;
        $display("[TB] FAIL pop1_can_pop[%0d]: got %0d expected %0d", c, can_pop, exp_cnt[c]);
      end
    end
    test_count++;
    if (can_push !== 3'd4) begin
      fail_count++;
      $display("[TB] FAIL pop1_can_push: got %0d expected 4", can_push);
    end
  endtask

  // rd=wr=3 here, so the three pushed words straddle the wrap point.
  task automatic test_wrap();
    logic [7:0] exp [3];
    exp = '{8'd6, 8'd7, 8'd8};
    push = 3'd3;
    push_data = {8'd9, 8'd8, 8'd7, 8'd6};
    step();
    push = '0;
    for (int i = 0; i < 3; i++) begin
      test_count++;
      if (pop_data[i] !== exp[i]) begin
        fail_count++;
        $display("[TB] FAIL wrap_data[%0d]: got %0d expected %0d", i, pop_data[i], exp[i]);
      end
    end
    pop = 3'd2;
    step();
    pop = '0;
    test_count++;
    if (can_pop !== 3'd1) begin
      fail_count++;
      $display("[TB] FAIL wrap_pop2_can_pop: got %0d expected 1", can_pop);
    end
    test_count++;
    if (pop_data[0] !== 8'd8) begin
      fail_count++;
      $display("[TB] FAIL wrap_pop2_head: got %0d expected 8", pop_data[0]);
    end
    pop = 3'd1;
    step();
    pop = '0;
  endtask

  task automatic test_full_clip();
    logic [7:0] exp [4];
    exp = '{8'd10, 8'd11, 8'd12, 8'd14};
    push = 3'd3;
    push_data = {8'd13, 8'd12, 8'd11, 8'd10};
    step();
    push_data = {8'd17, 8'd16, 8'd15, 8'd14};
    step();
    push = '0;
    test_count++;
    if (can_push !== 3'd0) begin
      fail_count++;
      $display("[TB] FAIL full_can_push: got %0d expected 0", can_push);
    end
    test_count++;
    if (can_pop !== 3'd4) begin
      fail_count++;
      $display("[TB] FAIL full_can_pop: got %0d expected 4", can_pop);
    end
    push = 3'd2;
    push_data = {8'd23, 8'd22, 8'd21, 8'd20};
    step();
    push = '0;
    test_count++;
    if (can_pop !== 3'd4) begin
      fail_count++;
      $display("[TB] FAIL full_ignore_can_pop: got %0d expected 4", can_pop);
    end
    for (int i = 0; i < 4; i++) begin
      test_count++;
      if (pop_data[i] !== exp[i]) begin
        fail_count++;
        $display("[TB] FAIL full_data[%0d]: got %0d expected %0d", i, pop_data[i], exp[i]);
      end
    end
    pop = 3'd4;
    step();
    pop = '0;
    test_count++;
    if (can_pop !== 3'd0 || can_push !== 3'd4) begin
      fail_count++;
      $display("[TB] FAIL full_drain: got can_pop=%0d can_push=%0d expected 0 and 4", can_pop, can_push);
    end
  endtask

  task automatic test_empty_pop();
    pop = 3'd4;
    step();
    pop = '0;
    test_count++;
    if (can_pop !== 3'd0 || can_push !== 3'd4) begin
      fail_count++;
      $display("[TB] FAIL empty_pop: got can_pop=%0d can_push=%0d expected 0 and 4", can_pop, can_push);
    end
    push = 3'd1;
    push_data = {8'd0, 8'd0, 8'd0, 8'd50};
    step();
    push = '0;
    test_count++;
    if (can_pop !== 3'd1 || pop_data[0] !== 8'd50) begin
      fail_count++;
      $display("[TB] FAIL empty_then_push: got can_pop=%0d head=%0d expected 1 and 50", can_pop, pop_data[0]);
    end
    pop = 3'd3;
    step();
    pop = '0;
    test_count++;
    if (can_pop !== 3'd0) begin
      fail_count++;
      $display("[TB] FAIL overpop_clip: got %0d expected 0", can_pop);
    end
  endtask

  task automatic test_simultaneous();
    push = 3'd2;
    push_data = {8'd0, 8'd0, 8'd31, 8'd30};
    step();
    push = 3'd2;
    pop = 3'd2;
    push_data = {8'd0, 8'd0, 8'd41, 8'd40};
    test_count++;
    if (can_push !== 3'd2 || can_pop !== 3'd2) begin
      fail_count++;
      $display("[TB] FAIL simul_no_comb: got can_push=%0d can_pop=%0d expected 2 and 2", can_push, can_pop);
    end
    step();
    push = '0;
    pop = '0;
    test_count++;
    if (can_pop !== 3'd2 || can_push !== 3'd2) begin
      fail_count++;
      $display("[TB] FAIL simul_count: got can_pop=%0d can_push=%0d expected 2 and 2", can_pop, can_push);
    end
    test_count++;
    if (pop_data[0] !== 8'd40 || pop_data[1] !== 8'd41) begin
      fail_count++;
      $display("[TB] FAIL simul_data: got %0d,%0d expected 40,41", pop_data[0], pop_data[1]);
    end
    pop = 3'd2;
    step();
    pop = '0;
  endtask

  task automatic test_async_reset();
    push = 3'd3;
    push_data = {8'd0, 8'd62, 8'd61, 8'd60};
    step();
    push = '0;
    test_count++;
    if (can_pop !== 3'd3) begin
      fail_count++;
      $display("[TB] FAIL pre_areset_can_pop: got %0d expected 3", can_pop);
    end
    #2 rst = 1'b0;
    #1;
    test_count++;
    if (can_pop !== 3'd0 || can_push !== 3'd4) begin
      fail_count++;
      $display("[TB] FAIL areset_immediate: got can_pop=%0d can_push=%0d expected 0 and 4", can_pop, can_push);
    end
    #1 rst = 1'b1;
    step();
    test_count++;
    if (can_pop !== 3'd0) begin
      fail_count++;
      $display("[TB] FAIL areset_after_release: got %0d expected 0", can_pop);
    end
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    test_reset();
    test_push_clip();
    test_pop_single();
    test_wrap();
    test_full_clip();
    test_empty_pop();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
